mul_issue_ctrl: RTL
===================

Name: mul_issue_ctrl

Overview:
- Issue-side scheduler for the fixed-latency multiply pipeline (MUL_LAT stages) and the single-cycle ALU path.
- Both paths share one register-file write port.
- Tracks every in-flight multiply. Stalls decode on RAW or WAW hazards against pending multiply destinations, and on write-port collisions.
- Drives the multiplier pipeline's valid input and reports which path owns writeback each cycle.

Parameters:
- REGISTER_WIDTH, params_pkg::REGISTER_WIDTH, register index width
- MUL_LAT, 5, cycles from mul issue edge to result-valid cycle at the multiplier output
- ALU_LAT, 1, cycles from non-mul issue edge to its writeback cycle; legal range 1..MUL_LAT-1
- ZERO_REG_HW, 1, when 1, register index 0 never produces a hazard

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  decode presents an instruction
- req_is_mul_i  in  1  instruction is a multiply
- req_rs1_i  in  REGISTER_WIDTH  source 1 index
- req_rs1_used_i  in  1  source 1 is read
- req_rs2_i  in  REGISTER_WIDTH  source 2 index
- req_rs2_used_i  in  1  source 2 is read
- req_rd_i  in  REGISTER_WIDTH  destination index
- req_rd_wr_i  in  1  instruction writes rd
- stall_o  out  1  decode must hold; combinational
- issue_o  out  1  req_valid_i & !stall_o; combinational
- mul_valid_o  out  1  issue_o & req_is_mul_i; drives multiplier valid_i
- wb_mul_o  out  1  current cycle's write port belongs to a multiply; registered
- inflight_cnt_o  out  $clog2(MUL_LAT+1)  multiplies currently tracked; registered
- busy_o  out  1  inflight_cnt_o != 0

Behaviour:
- Tracking is a MUL_LAT-entry age shift register; entry k (1..MUL_LAT) = {v, wr, rd}.
- At each edge:
  - entry k+1 <= entry k.
  - Entry MUL_LAT drops out.
  - Entry 1 <= {mul_valid_o, req_rd_wr_i, req_rd_i}.
- Timing for a mul issued in cycle t:
  - occupies ages 1..MUL_LAT during cycles t+1..t+MUL_LAT;
  - writes back in cycle t+MUL_LAT;
  - dependents may issue from cycle t+MUL_LAT+1, since there is no forwarding.
- Hazard terms; an entry "matches" when v & wr & rd equal and not (ZERO_REG_HW & index==0):
  - RAW: req_rs1_used_i & rs1 matches any entry, or likewise for rs2.
  - WAW: !req_is_mul_i & req_rd_wr_i & rd matches any entry. Mul-after-mul WAW is allowed because writeback order is preserved.
  - Port collision: !req_is_mul_i & req_rd_wr_i & entry (MUL_LAT-ALU_LAT) has v & wr.
- stall_o = req_valid_i & (RAW | WAW | collision). stall_o is 0 when req_valid_i=0.
- A stalled request leaves no tracking state; decode re-presents it next cycle.
- wb_mul_o = entry MUL_LAT v & wr, i.e. a mul result with writeback is present this cycle.
- inflight_cnt_o = count of v over all entries, registered. Maximum is MUL_LAT (back-to-back muls).
- A mul with req_rd_wr_i=0 is still counted but never hazards.
- Reset (asynchronous, rst_i=0):
  - all entries v=0, wr=0, rd=0;
  - inflight_cnt_o=0, wb_mul_o=0, busy_o=0;
  - stall_o and issue_o are still driven combinationally from the cleared state.
- Reset mid-operation discards tracking. The multiplier pipeline is reset by the same signal, so no orphan results exist.
- Simultaneous issue and retire in the same edge: the count changes by (+1 issue) + (−1 retire) and nets 0.

Test Plan:
- Reset, then mul rd=5 issued at cycle 0, next request is add rs1=5 → stall_o=1 in cycles 1..5, issue_o=1 in cycle 6; wb_mul_o=1 only in cycle 5.
- Five back-to-back muls rd=1..5, no reads → no stalls; inflight_cnt_o ramps 1,2,3,4,5, holds at 5 while issuing, then falls 4..0 after issue stops.
- Mul rd=3 at cycle 0, add rd=7 (no sources) presented in cycle 4 → stall_o=1 (port collision at age 4); issues in cycle 5, writes back in cycle 6.
- Mul rd=0 then add rs1=0,rd=0 at cycle 1 with ZERO_REG_HW=1 → no RAW or WAW stall; the cycle-4 collision rule still applies.
- Mul rd=9 at cycle 0, add rd=9 (WAW) at cycle 1 → stalled cycles 1..5; a second mul rd=9 at cycle 1 issues with no stall.
- rst_i asserted low at cycle 2 with 2 muls in flight → inflight_cnt_o=0 and wb_mul_o=0 immediately; a dependent read issues with no stall after reset release.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// Issue-side scheduler for the fixed-latency multiplier and the single-cycle ALU path.
// Tracks in-flight multiplies by age and stalls decode on RAW/WAW hazards and write-port collisions.
package params_pkg;
  localparam int REGISTER_WIDTH = 5;
endpackage

module mul_issue_ctrl #(
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int MUL_LAT        = 5,
  parameter int ALU_LAT        = 1,
  parameter int ZERO_REG_HW    = 1,
  localparam int CNT_W         = $clog2(MUL_LAT + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  input  logic                      req_is_mul_i,
  input  logic [REGISTER_WIDTH-1:0] req_rs1_i,
  input  logic                      req_rs1_used_i,
  input  logic [REGISTER_WIDTH-1:0] req_rs2_i,
  input  logic                      req_rs2_used_i,
  input  logic [REGISTER_WIDTH-1:0] req_rd_i,
  input  logic                      req_rd_wr_i,
  output logic                      stall_o,
  output logic                      issue_o,
  output logic                      mul_valid_o,
  output logic                      wb_mul_o,
  output logic [CNT_W-1:0]          inflight_cnt_o,
  output logic                      busy_o
);

  // An ALU op issued now lands on the write port in the same cycle as the mul at this age.
  localparam int COL_AGE = MUL_LAT - ALU_LAT;

  logic [MUL_LAT:1]          v_reg;
  logic [MUL_LAT:1]          wr_reg;
  logic [REGISTER_WIDTH-1:0] rd_reg [1:MUL_LAT];
  logic [CNT_W-1:0]          cnt_reg;

  logic [MUL_LAT:1] live;
  logic [MUL_LAT:1] rs1_hit;
  logic [MUL_LAT:1] rs2_hit;
  logic [MUL_LAT:1] rd_hit;
  logic             rs1_zero;
  logic             rs2_zero;
  logic             rd_zero;
  logic             raw;
  logic             waw;
  logic             collision;

  assign live     = v_reg & wr_reg;
  assign rs1_zero = (ZERO_REG_HW != 0) && (req_rs1_i == '0);
  assign rs2_zero = (ZERO_REG_HW != 0) && (req_rs2_i == '0);
  assign rd_zero  = (ZERO_REG_HW != 0) && (req_rd_i == '0);

  genvar gi;
  generate
    for (gi = 1; gi <= MUL_LAT; gi++) begin : g_match
      assign rs1_hit[gi] = live[gi] && (rd_reg[gi] == req_rs1_i) && !rs1_zero;
      assign rs2_hit[gi] = live[gi] && (rd_reg[gi] == req_rs2_i) && !rs2_zero;
      assign rd_hit[gi]  = live[gi] && (rd_reg[gi] == req_rd_i)  && !rd_zero;
    end
  endgenerate

  // Mul-after-mul WAW is safe: the pipeline retires in issue order.
  assign raw       = (req_rs1_used_i && (|rs1_hit)) || (req_rs2_used_i && (|rs2_hit));
  assign waw       = !req_is_mul_i && req_rd_wr_i && (|rd_hit);
  assign collision = !req_is_mul_i && req_rd_wr_i && live[COL_AGE];

  assign stall_o     = req_valid_i && (raw || waw || collision);
  assign issue_o     = req_valid_i && !stall_o;
  assign mul_valid_o = issue_o && req_is_mul_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v_reg  <= '0;
      wr_reg <= '0;
      for (int i = 1; i <= MUL_LAT; i++) begin
        rd_reg[i] <= '0;
      end
    end else begin
      v_reg     <= {v_reg[MUL_LAT-1:1], mul_valid_o};
      wr_reg    <= {wr_reg[MUL_LAT-1:1], req_rd_wr_i};
      rd_reg[1] <= req_rd_i;
      for (int i = 2; i <= MUL_LAT; i++) begin
        rd_reg[i] <= rd_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(mul_valid_o) - CNT_W'(v_reg[MUL_LAT]);
    end
  end

  assign wb_mul_o       = live[MUL_LAT];
  assign inflight_cnt_o = cnt_reg;
  assign busy_o         = (cnt_reg != '0);

endmodule
